lsu_ctrl: RTL
=============

Name: lsu_ctrl

Overview:
- Load/store sequencer between the MEM pipeline stage and a valid/ready data-memory bus.
- Takes the decoded memory controls (read/write enable, load type, store type) plus address and store data.
- Drives one bus transaction per request, generates byte enables and lane-aligned write data, and formats/extends load data.
- Stalls the pipeline until the access completes, and times out hung transactions.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles spent in REQ+WAIT before abort; 8-bit counter, legal 1..255.
- ADDR_W, 32: address width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- req_read  in  1  load request (data_mem_read)
- req_write  in  1  store request (data_mem_write)
- req_load_type  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- req_store_type  in  2  0 SB, 1 SH, 2 SW
- req_addr  in  ADDR_W  byte address from ALU
- req_wdata  in  32  rs2 store data
- stall  out  1  hold pipeline registers
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse with done on timeout/misalign
- rdata  out  32  formatted load result, valid when done and a load
- mem_valid  out  1  bus request
- mem_ready  in  1  bus accept
- mem_we  out  1  1 = write
- mem_be  out  4  byte enables
- mem_addr  out  ADDR_W  {req_addr[ADDR_W-1:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_rvalid  in  1  read response valid
- mem_rdata  in  32  read response word

Behaviour:
- Reset values (synchronous, active-low): state=IDLE; mem_valid=0; mem_we=0; mem_be=0; mem_addr=0; mem_wdata=0; done=0; err=0; rdata=0; timeout counter=0.
- States: IDLE, REQ, WAIT, DONE.
- IDLE, with req_read|req_write:
  - Capture the request into registers and go to REQ.
  - If both are set, the write wins and the read is ignored.
- stall is combinational: (IDLE & (req_read|req_write)) | REQ | WAIT. It is 0 in DONE, so the pipeline advances exactly once per request.
- REQ:
  - mem_valid=1, with address/be/wdata/we held stable until mem_ready.
  - On accept, a write goes to DONE and a read goes to WAIT.
- WAIT: on mem_rvalid, latch the formatted mem_rdata into rdata and go to DONE.
- DONE: done=1 for one cycle, then IDLE. A new request seen in IDLE on the following cycle is a new instruction.
- Timeout:
  - The counter clears on entry to REQ and increments every REQ/WAIT cycle.
  - When it reaches TIMEOUT_CYCLES: drop mem_valid, go to DONE with err=1, rdata=0.
- Minimum latency with a zero-wait bus (ready same cycle, rvalid next):
  - Store: stall for 2 cycles, done in cycle 3.
  - Load: stall for 3 cycles, done in cycle 4.
- Store lanes:
  - SB: be=0001<<addr[1:0], wdata={4{b}}.
  - SH: be=0011<<{addr[1],0}, wdata={2{h}}.
  - SW: be=1111.
- Load lanes:
  - LB/LBU: byte at addr[1:0], sign- or zero-extended.
  - LH/LHU: half at addr[1].
  - LW: full word.
  - Undefined load_type codes (011, 110, 111) behave as LW.
- Reads drive be=1111.
- mem_rvalid outside WAIT is ignored. mem_ready outside REQ is ignored.
- Reset mid-transaction returns to IDLE on that edge, and any late response is dropped.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned requests are detected in IDLE: a halfword with addr[0]=1, or a word with addr[1:0]!=0.
  - Detection skips the bus and goes straight to DONE with err=1 and rdata=0, giving one stall cycle.
- Undefined:
  - No misalign detection.
  - Halfword ignores addr[0]; word ignores addr[1:0].
  - err only on timeout.

Decomposition:
- Shared package/include riscv_defs: LOAD_*/STORE_* codes (same encodings the decoder uses), LSU state encodings, bus width localparams.
- One combinational sub-module, lsu_align: the store lane/be generator and the load extract/extend. Reused by any future cache path.

Test Plan:
- SB, addr 0x1003, wdata 0x000000AB, zero-wait bus -> mem_be=1000, mem_wdata=0xABABABAB, mem_addr=0x1000, stall high 2 cycles, done in cycle 3.
- LB, addr 0x2001, mem_rdata 0x0000_80FF -> rdata=0xFFFFFF80. LBU at the same address -> 0x00000080. LHU, addr 0x2002, mem_rdata 0x8001_0000 -> 0x00008001.
- LW with mem_ready held low 5 cycles and rvalid 3 cycles after accept -> mem_valid and address stable throughout, stall high, single done pulse, rdata=mem_rdata.
- TIMEOUT_CYCLES=4, mem_ready never asserted -> mem_valid drops after 4 cycles, done=err=1 for one cycle, rdata=0, then IDLE.
- Back-to-back SW then LW with req held by stall -> exactly two bus transactions, no duplicate. Assert rst_n=0 while in WAIT, then send rvalid -> IDLE, no done, response ignored.
- LSU_MISALIGN_TRAP_EN defined, LH at 0x3001 -> no mem_valid, done=err=1 on the next cycle. Undefined -> bus read with be=1111, and rdata taken from the addr[1]=0 lane.

Source files
------------

// File: rtl/riscv_defs_pkg.sv
// Shared memory-access definitions: load/store type codes matching the
// decoder, LSU sequencer state encodings and data-bus widths.
package riscv_defs_pkg;

  localparam int unsigned BUS_DATA_W = 32;
  localparam int unsigned BUS_BE_W   = BUS_DATA_W / 8;

  localparam logic [2:0] LOAD_LB  = 3'b000;
  localparam logic [2:0] LOAD_LH  = 3'b001;
  localparam logic [2:0] LOAD_LW  = 3'b010;
  localparam logic [2:0] LOAD_LBU = 3'b100;
  localparam logic [2:0] LOAD_LHU = 3'b101;

  localparam logic [1:0] STORE_SB = 2'd0;
  localparam logic [1:0] STORE_SH = 2'd1;
  localparam logic [1:0] STORE_SW = 2'd2;

  localparam logic [1:0] LSU_IDLE = 2'd0;
  localparam logic [1:0] LSU_REQ  = 2'd1;
  localparam logic [1:0] LSU_WAIT = 2'd2;
  localparam logic [1:0] LSU_DONE = 2'd3;

  // Halfword at an odd address, or word off a 4-byte boundary. Undefined
  // load/store codes are word-sized, matching how the datapath treats them.
  function automatic logic lsu_misaligned(input logic       is_store,
                                          input logic [2:0] ld_type,
                                          input logic [1:0] st_type,
                                          input logic [1:0] off);
    logic half;
    logic word;
    if (is_store) begin
      half = (st_type == STORE_SH);
      word = (st_type != STORE_SB) && !half;
    end else begin
      half = (ld_type == LOAD_LH) || (ld_type == LOAD_LHU);
      word = !half && (ld_type != LOAD_LB) && (ld_type != LOAD_LBU);
    end
    return (half && off[0]) || (word && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane alignment for the data-memory path: store byte-enable/lane
// replication and load byte/half extraction with sign or zero extension.
// Purely combinational so a cache path can reuse it unchanged.
module lsu_align
  import riscv_defs_pkg::*;
(
  input  logic [1:0]            st_type_i,
  input  logic [1:0]            st_off_i,
  input  logic [BUS_DATA_W-1:0] st_wdata_i,
  output logic [BUS_BE_W-1:0]   st_be_o,
  output logic [BUS_DATA_W-1:0] st_wdata_o,
  input  logic [2:0]            ld_type_i,
  input  logic [1:0]            ld_off_i,
  input  logic [BUS_DATA_W-1:0] ld_rdata_i,
  output logic [BUS_DATA_W-1:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store side: replicate the datum across lanes and enable only its bytes.
  always_comb begin
    st_be_o    = 4'b1111;
    st_wdata_o = st_wdata_i;
    case (st_type_i)
      STORE_SB: begin
        st_be_o    = 4'b0001 << st_off_i;
        st_wdata_o = {4{st_wdata_i[7:0]}};
      end
      STORE_SH: begin
        st_be_o    = st_off_i[1] ? 4'b1100 : 4'b0011;
        st_wdata_o = {2{st_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Load side: pick the addressed lane, then extend; unknown codes read as LW.
  always_comb begin
    ld_byte = ld_rdata_i[7:0];
    case (ld_off_i)
      2'd1:    ld_byte = ld_rdata_i[15:8];
      2'd2:    ld_byte = ld_rdata_i[23:16];
      2'd3:    ld_byte = ld_rdata_i[31:24];
      default: ld_byte = ld_rdata_i[7:0];
    endcase
    ld_half = ld_off_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
    case (ld_type_i)
      LOAD_LB:  ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      LOAD_LBU: ld_data_o = {24'd0, ld_byte};
      LOAD_LH:  ld_data_o = {{16{ld_half[15]}}, ld_half};
      LOAD_LHU: ld_data_o = {16'd0, ld_half};
      default:  ld_data_o = ld_rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer between the MEM stage and a valid/ready data bus.
// One bus transaction per request; stalls the pipeline until completion and
// aborts hung transactions after TIMEOUT_CYCLES cycles in REQ+WAIT.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned half/word requests
// skip the bus and complete with err.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | no access in flight; captures a new request
//   REQ   | mem_valid high, request held until mem_ready
//   WAIT  | read accepted, waiting for mem_rvalid
//   DONE  | one-cycle done (and err on abort); pipeline advances
module lsu_ctrl
  import riscv_defs_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [2:0]        req_load_type,
  input  logic [1:0]        req_store_type,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

  logic [1:0]        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        ld_type_q, ld_type_d;
  logic [1:0]        off_q, off_d;

  logic              req_any;
  logic [3:0]        st_be;
  logic [31:0]       st_wdata;
  logic [31:0]       ld_data;
  logic [7:0]        cnt_inc;
  logic              timeout_hit;

  assign req_any     = req_read | req_write;
  assign cnt_inc     = cnt_q + 8'd1;
  assign timeout_hit = (cnt_inc == TO_LIMIT);

  lsu_align u_align (
    .st_type_i  (req_store_type),
    .st_off_i   (req_addr[1:0]),
    .st_wdata_i (req_wdata),
    .st_be_o    (st_be),
    .st_wdata_o (st_wdata),
    .ld_type_i  (ld_type_q),
    .ld_off_i   (off_q),
    .ld_rdata_i (mem_rdata),
    .ld_data_o  (ld_data)
  );

  // Next-state and capture logic; write wins when both requests are set.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    we_d      = we_q;
    be_d      = be_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    ld_type_d = ld_type_q;
    off_d     = off_q;
    case (state_q)
      LSU_IDLE: begin
        if (req_any) begin
          we_d      = req_write;
          addr_d    = {req_addr[ADDR_W-1:2], 2'b00};
          off_d     = req_addr[1:0];
          ld_type_d = req_load_type;
          be_d      = req_write ? st_be : 4'b1111;
          wdata_d   = req_write ? st_wdata : 32'd0;
          rdata_d   = 32'd0;
          cnt_d     = 8'd0;
          err_d     = 1'b0;
          state_d   = LSU_REQ;
`ifdef LSU_MISALIGN_TRAP_EN
          if (lsu_misaligned(req_write, req_load_type, req_store_type, req_addr[1:0])) begin
            err_d   = 1'b1;
            state_d = LSU_DONE;
          end
`endif
        end
      end
      LSU_REQ: begin
        cnt_d = cnt_inc;
        if (mem_ready) begin
          state_d = we_q ? LSU_DONE : LSU_WAIT;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          rdata_d = 32'd0;
          state_d = LSU_DONE;
        end
      end
      LSU_WAIT: begin
        cnt_d = cnt_inc;
        if (mem_rvalid) begin
          rdata_d = ld_data;
          state_d = LSU_DONE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          rdata_d = 32'd0;
          state_d = LSU_DONE;
        end
      end
      default: begin
        err_d   = 1'b0;
        state_d = LSU_IDLE;
      end
    endcase
  end

  // State and request registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= LSU_IDLE;
      cnt_q     <= 8'd0;
      err_q     <= 1'b0;
      rdata_q   <= 32'd0;
      we_q      <= 1'b0;
      be_q      <= 4'd0;
      addr_q    <= '0;
      wdata_q   <= 32'd0;
      ld_type_q <= 3'd0;
      off_q     <= 2'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      we_q      <= we_d;
      be_q      <= be_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      ld_type_q <= ld_type_d;
      off_q     <= off_d;
    end
  end

  assign stall     = ((state_q == LSU_IDLE) && req_any) ||
                     (state_q == LSU_REQ) || (state_q == LSU_WAIT);
  assign done      = (state_q == LSU_DONE);
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign mem_valid = (state_q == LSU_REQ);
  assign mem_we    = we_q;
  assign mem_be    = be_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule
